// File: rtl/exmem_skid_buffer.sv
// Two-entry EX/MEM elastic register: one-cycle latency, full throughput while mem_ready is high.
// A skid slot absorbs one in-flight entry under backpressure; ex_ready and mem_valid come straight from flops.
module exmem_skid_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   ex_ready_q, ex_ready_d;
  logic   accept, pop;

  // State and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      ex_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      ex_ready_q <= ex_ready_d;
    end
  end

  // Next-state and datapath steering
  always_comb begin
    in_entry            = '0;
    in_entry.result     = ex_result;
    in_entry.store_data = ex_store_data;
    in_entry.rd         = ex_rd;
    // Writes to x0 are dropped here so forwarding never has to re-check them.
    in_entry.regwrite   = ex_regwrite & (ex_rd != '0);
    in_entry.memread    = ex_memread;
    in_entry.memwrite   = ex_memwrite;

    accept  = ex_valid & ex_ready_q;
    pop     = (state_q != ST_EMPTY) & mem_ready;

    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_d  = in_entry;
          end else if (accept) begin
            skid_d  = in_entry;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    ex_ready_d = (state_d != ST_TWO);
  end

  // Outputs: all driven from registered state and the head entry
  always_comb begin
    ex_ready       = ex_ready_q;
    mem_valid      = (state_q != ST_EMPTY);
    mem_result     = head_q.result;
    mem_store_data = head_q.store_data;
    mem_rd         = head_q.rd;
    mem_regwrite   = head_q.regwrite;
    mem_memread    = head_q.memread;
    mem_memwrite   = head_q.memwrite;
    fwd_en         = mem_valid & head_q.regwrite & (head_q.rd != '0);
    fwd_rd         = head_q.rd;
    fwd_data       = head_q.result;
  end

endmodule

// File: tb/tb_exmem_skid_buffer.sv
// Scoreboard bench for exmem_skid_buffer: directed scenarios plus a randomised soak.
module tb_exmem_skid_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic        mem_regwrite, mem_memread, mem_memwrite;
  logic        fwd_en;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exmem_skid_buffer #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_result(mem_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; expected entry is queued when the edge accepts it.
  task automatic cyc(input logic v, input logic [31:0] res, input logic [31:0] sd,
                     input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                     input logic mrdy, input logic fl);
    logic acc;
    exp_t e;
    ex_valid = v; ex_result = res; ex_store_data = sd; ex_rd = rd;
    ex_regwrite = rw; ex_memread = mr; ex_memwrite = mw;
    mem_ready = mrdy; flush = fl;
    @(negedge clk);
    acc = v && ex_ready && !fl && !rst;
    e.result = res; e.store_data = sd; e.rd = rd;
    e.regwrite = rw && (rd != 5'd0); e.memread = mr; e.memwrite = mw;
    @(posedge clk);
    if (acc) exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input logic mrdy);
    cyc(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, mrdy, 1'b0);
  endtask

  // Monitor: compares head against the scoreboard between edges and retires on pop.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("occ_mem_valid", {31'd0, mem_valid}, {31'd0, exp_q.size() != 0});
      chk("occ_ex_ready", {31'd0, ex_ready}, {31'd0, exp_q.size() < 2});
      if (mem_valid && exp_q.size() != 0) begin
        chk("mem_result", mem_result, exp_q[0].result);
        chk("mem_store_data", mem_store_data, exp_q[0].store_data);
        chk("mem_rd", {27'd0, mem_rd}, {27'd0, exp_q[0].rd});
        chk("mem_ctrl", {29'd0, mem_regwrite, mem_memread, mem_memwrite},
            {29'd0, exp_q[0].regwrite, exp_q[0].memread, exp_q[0].memwrite});
        chk("fwd_en", {31'd0, fwd_en}, {31'd0, exp_q[0].regwrite && exp_q[0].rd != 5'd0});
        chk("fwd_rd", {27'd0, fwd_rd}, {27'd0, exp_q[0].rd});
        chk("fwd_data", fwd_data, exp_q[0].result);
        if (mem_ready) void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
    ex_result = '0; ex_store_data = '0; ex_rd = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    #12;
    chk("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("reset_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("reset_fwd_en", {31'd0, fwd_en}, 32'd0);
    chk("reset_mem_result", mem_result, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Streaming: each entry shows up right after the edge that accepts it
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'h10 + i, 32'h100 + i, 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("stream_ex_ready", {31'd0, ex_ready}, 32'd1);
      chk("stream_mem_valid", {31'd0, mem_valid}, 32'd1);
      chk("stream_result", mem_result, 32'h10 + i);
    end
    idle(1'b1);
    chk("stream_drained", {31'd0, mem_valid}, 32'd0);

    // Skid
    cyc(1'b1, 32'hA, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'hB, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("skid_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("skid_hold_a", mem_result, 32'hA);
    idle(1'b0);
    chk("skid_still_a", mem_result, 32'hA);
    idle(1'b1);
    chk("skid_then_b", mem_result, 32'hB);
    chk("skid_ready_back", {31'd0, ex_ready}, 32'd1);
    idle(1'b1);
    chk("skid_empty", {31'd0, mem_valid}, 32'd0);

    // Flush from TWO with a colliding new entry
    cyc(1'b1, 32'h1, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h2, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush_pre_two", {31'd0, ex_ready}, 32'd0);
    cyc(1'b1, 32'hC, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("flush_ex_ready", {31'd0, ex_ready}, 32'd1);
    idle(1'b1);
    chk("flush_no_c", {31'd0, mem_valid}, 32'd0);

    // x0 writes are suppressed, real writes forwarded
    cyc(1'b1, 32'hDEAD, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("x0_regwrite", {31'd0, mem_regwrite}, 32'd0);
    chk("x0_fwd_en", {31'd0, fwd_en}, 32'd0);
    cyc(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fwd_en_r5", {31'd0, fwd_en}, 32'd1);
    chk("fwd_rd_r5", {27'd0, fwd_rd}, 32'd5);
    chk("fwd_data_r5", fwd_data, 32'h1234);
    idle(1'b1);

    // Asynchronous reset while full
    cyc(1'b1, 32'h21, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst_pre_two", {31'd0, ex_ready}, 32'd0);
    ex_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("arst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("arst_fwd_en", {31'd0, fwd_en}, 32'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 32'h55, 32'h66, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("arst_after_valid", {31'd0, mem_valid}, 32'd1);
    chk("arst_after_result", mem_result, 32'h55);
    idle(1'b1);

    // Random soak, scoreboard does all checking
    for (int n = 0; n < 10000; n++) begin
      cyc($urandom_range(99) < 30, $urandom, $urandom, 5'($urandom_range(31)),
          1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(99) < 30, $urandom_range(99) < 30);
    end
    for (int n = 0; n < 4; n++) idle(1'b1);
    chk("final_empty", {31'd0, mem_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exmem_skid_buffer.md
# exmem_skid_buffer

Two-entry elastic pipeline register between the execute stage (ALU, shifter, comparator) and the memory stage of the RISC core. It captures the 32-bit ALU/shift result together with destination and control bits under a valid/ready handshake. It absorbs one cycle of memory-stage backpressure without combinational ready paths, supports a pipeline flush, and exposes the oldest held result for operand forwarding back to execute.

## Interface
- DATA_W, 32, width of result and store-data fields
- REG_W, 5, width of destination register index
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous flush; discards all held and incoming entries
- ex_valid  in  1  execute stage presents an entry
- ex_ready  out  1  buffer accepts; registered, depends only on occupancy
- ex_result  in  DATA_W  ALU/shift result (address for loads and stores)
- ex_store_data  in  DATA_W  rs2 value for stores
- ex_rd  in  REG_W  destination register
- ex_regwrite, ex_memread, ex_memwrite  in  1 each  control bits
- mem_valid  out  1  head entry valid
- mem_ready  in  1  memory stage consumes head
- mem_result, mem_store_data  out  DATA_W  head fields
- mem_rd  out  REG_W  head destination
- mem_regwrite, mem_memread, mem_memwrite  out  1 each  head control bits
- fwd_en  out  1  head is valid, has regwrite=1 and rd≠0
- fwd_rd  out  REG_W  equals mem_rd
- fwd_data  out  DATA_W  equals mem_result

## Operation
- Storage: head register H (drives mem_* outputs) and skid register S, each with a valid bit. States: EMPTY (no entries), ONE (H valid), TWO (H and S valid).
- Accept = ex_valid & ex_ready. Pop = mem_valid & mem_ready.
- EMPTY: accept -> load H, go to ONE.
- ONE: accept & pop -> load H with the new entry, stay in ONE. Accept & !pop -> load S, go to TWO. Pop & !accept -> go to EMPTY. Neither -> hold.
- TWO: ex_ready=0, so no accept. Pop -> H←S, go to ONE. No pop -> hold.
- ex_ready = (state≠TWO), registered from next-state.
- Capture rule: when ex_rd==0, ex_regwrite is stored as 0. No other field is modified.
- Order is strict FIFO; an entry is never duplicated or dropped except by flush.
- Flush: takes priority over accept and pop. Next state is EMPTY, and an entry presented in the flush cycle is discarded. mem_valid is still 1 during the flush cycle if H was valid; the memory stage may consume it in that cycle. Data fields need not clear.
- Outputs are driven only from H; mem_* data fields are don't-care when mem_valid=0 but must remain stable while mem_valid=1 and mem_ready=0.
- fwd_en = mem_valid & mem_regwrite & (mem_rd≠0). The S entry is not forwarded; execute stalls via ex_ready.

## Timing
- Reset (async assert, sync release at clk edge): state EMPTY, mem_valid=0, ex_ready=1, fwd_en=0, all data/control registers 0.
- Latency: an entry accepted at edge N is visible on mem_* after edge N (one cycle), with mem_valid=1 in cycle N+1.
- Throughput: one entry per cycle while mem_ready stays high.
- Backpressure: mem_ready low for one cycle with continuous input moves to TWO; ex_ready falls one cycle later. No entry is lost because S absorbs the in-flight one.
- ex_ready and mem_valid have no combinational path from any input.
- Reset mid-operation: all entries are lost immediately on rst assertion; outputs reach reset values without a clock.

## Test plan
- Streaming: 8 back-to-back entries with result=0x10..0x17, rd=1..8, mem_ready=1 -> mem_result 0x10..0x17 in order, one per cycle, first one cycle after the first accept, ex_ready stays 1.
- Skid: with the buffer in ONE holding 0xA, present 0xB with mem_ready=0 -> state TWO, ex_ready=0 next cycle, mem_result holds 0xA. Then raise mem_ready -> 0xA, then 0xB consumed, ex_ready returns to 1.
- Flush: with the buffer in TWO, assert flush together with ex_valid=1 and data 0xC -> next cycle mem_valid=0, ex_ready=1; 0xC never appears.
- x0 write: accept rd=0, regwrite=1, result=0xDEAD -> mem_regwrite=0, fwd_en=0. Accept rd=5, regwrite=1, result=0x1234 -> fwd_en=1, fwd_rd=5, fwd_data=0x1234.
- Async reset: assert rst mid-stream between clock edges with state TWO -> mem_valid=0, ex_ready=1, fwd_en=0 immediately; after release, the first accepted entry passes normally.
- Random: random ex_valid/mem_ready/flush at 30% each for 10k cycles against a scoreboard -> FIFO order is preserved, there is no loss outside flush, and outputs stay stable under stall.
